spi_counter_sender: RTL and testbench

//  Master-side source for the SPI counter-display link.
//  - Runs a 0..9999 tick counter.
//  - Sends each new count as a 2-byte SPI frame to the display slave:

---
 rtl/spi_counter_sender.sv | 155 +++++++++++++++
 tb/tb_spi_counter_sender.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_counter_sender.sv
// spi_counter_sender: 0..CNT_MAX tick counter that ships each new value to the display as a 2-byte SPI frame.
// Build option SPI_SENDER_FRAME_GAP_EN stretches the inter-frame ss-high gap to GAP_CYCLES cycles.
module spi_counter_sender #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TICK_HZ    = 10,
  parameter int unsigned CNT_MAX    = 9999,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  input  logic        m_ready,
  input  logic        m_done,
  output logic        m_start,
  output logic [7:0]  m_tx_data,
  output logic        ss,
  output logic [13:0] count,
  output logic        busy
);

  localparam int unsigned CNT_W = 14;
  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1 || CNT_MAX >= (1 << CNT_W) || GAP_CYCLES < 1) begin : g_bad_cfg
    $error("spi_counter_sender: invalid parameter set");
  end

  typedef enum logic [2:0] {
    IDLE, SETUP, HI_REQ, HI_WAIT, LO_REQ, LO_WAIT, GAP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic             tick_c;
  logic             pending_q;
  logic             leave_idle_c;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic             ss_d;
  logic             m_start_d;
  logic [7:0]       tx_d;
  logic             gap_done_c;

  // Free-running tick divider
  assign tick_c = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      div_q <= '0;
    else if (tick_c) div_q <= '0;
    else             div_q <= div_q + DIV_W'(1);
  end

  // Counter and pending flag; a new event wins over the IDLE handshake so it is never lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      pending_q <= 1'b1;
    end else if (clear) begin
      count     <= '0;
      pending_q <= 1'b1;
    end else if (tick_c && run) begin
      count     <= (count == CNT_W'(CNT_MAX)) ? '0 : count + CNT_W'(1);
      pending_q <= 1'b1;
    end else if (leave_idle_c) begin
      pending_q <= 1'b0;
    end
  end

`ifdef SPI_SENDER_FRAME_GAP_EN
  localparam int unsigned GAP_W = GAP_CYCLES;
  logic [GAP_W-1:0] gap_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              gap_q <= '0;
    else if (state_q == GAP) gap_q <= gap_q + GAP_W'(1);
    else                     gap_q <= '0;
  end

  assign gap_done_c = (gap_q == GAP_W'(GAP_CYCLES - 1));
`else
  assign gap_done_c = 1'b1;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    ss_d         = ss;
    m_start_d    = 1'b0;
    tx_d         = m_tx_data;
    leave_idle_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          leave_idle_c = 1'b1;
          snap_d       = count;
          ss_d         = 1'b0;
          state_d      = SETUP;
        end
      end
      SETUP: state_d = HI_REQ;
      HI_REQ: begin
        if (m_ready) begin
          tx_d      = {2'b00, snap_q[13:8]};
          m_start_d = 1'b1;
          state_d   = HI_WAIT;
        end
      end
      HI_WAIT: begin
        if (m_done) state_d = LO_REQ;
      end
      LO_REQ: begin
        if (m_ready) begin
          tx_d      = snap_q[7:0];
          m_start_d = 1'b1;
          state_d   = LO_WAIT;
        end
      end
      LO_WAIT: begin
        if (m_done) begin
          ss_d    = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_done_c) state_d = IDLE;
      end
      default: begin
        ss_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      ss        <= 1'b1;
      m_start   <= 1'b0;
      m_tx_data <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      ss        <= ss_d;
      m_start   <= m_start_d;
      m_tx_data <= tx_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_spi_counter_sender.sv
// Scoreboard bench for spi_counter_sender: directed scenarios push expected frames, a monitor checks each ss window.
`timescale 1ns/1ps
module tb_spi_counter_sender;

  localparam int unsigned CLK_HZ     = 2;
  localparam int unsigned TICK_HZ    = 1;
  localparam int unsigned DIV        = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_MAX    = 9999;
  localparam int unsigned GAP_CYCLES = 16;
`ifdef SPI_SENDER_FRAME_GAP_EN
  localparam int unsigned EXP_GAP = GAP_CYCLES;
`else
  localparam int unsigned EXP_GAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, run, clear, m_ready, m_done;
  logic        m_start, ss, busy;
  logic [7:0]  m_tx_data;
  logic [13:0] count;

  int          checks = 0;
  int          errors = 0;
  bit          master_en = 1'b1;
  int          hold_idx = -1;
  int          starts_seen = 0;
  int unsigned model_cnt, model_div;
  logic [15:0] exp_q[$];
  int unsigned last_gap = 0;

  spi_counter_sender #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CNT_MAX(CNT_MAX), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear),
    .m_ready(m_ready), .m_done(m_done), .m_start(m_start), .m_tx_data(m_tx_data),
    .ss(ss), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference counter: divider of DIV cycles, clear beats tick, wrap after CNT_MAX
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_cnt <= 0;
      model_div <= 0;
    end else begin
      if (clear) model_cnt <= 0;
      else if (run && model_div == DIV - 1) model_cnt <= (model_cnt == CNT_MAX) ? 0 : model_cnt + 1;
      model_div <= (model_div == DIV - 1) ? 0 : model_div + 1;
    end
  end

  // spi_master stand-in: m_done 8 cycles after m_start unless that byte index is held
  initial begin : master_bfm
    int busy_cnt;
    int cur_idx;
    busy_cnt = 0;
    cur_idx  = 0;
    m_ready  = 1'b1;
    m_done   = 1'b0;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (!reset) begin
        busy_cnt = 0;
        m_ready  = master_en;
      end else if (m_start) begin
        check("start_needs_ready", 32'(m_ready), 32'd1);
        starts_seen++;
        cur_idx  = starts_seen;
        busy_cnt = 8;
        m_ready  = 1'b0;
      end else if (busy_cnt > 0) begin
        if (cur_idx != hold_idx) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            m_done  = 1'b1;
            m_ready = master_en;
          end
        end
      end else begin
        m_ready = master_en;
      end
    end
  end

  // Frame monitor: collects bytes per ss-low window and pops the scoreboard on ss rising
  initial begin : monitor
    logic [7:0]  cap [2];
    logic [15:0] exp_w;
    int          nbytes;
    int unsigned hi_len;
    bit          have_prev;
    logic        ss_prev;
    nbytes = 0; hi_len = 0; have_prev = 1'b0; ss_prev = 1'b1;
    cap[0] = '0; cap[1] = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        nbytes = 0; hi_len = 0; have_prev = 1'b0; ss_prev = 1'b1;
        continue;
      end
      if (ss_prev && !ss) begin
        last_gap = hi_len;
        if (have_prev) begin
          checks++;
          if (hi_len < EXP_GAP + 1) begin
            errors++;
            $display("FAIL gap_min: got %0d ss-high cycles, required >= %0d", hi_len, EXP_GAP + 1);
          end
        end
        nbytes = 0;
      end
      if (m_start) begin
        check("start_in_window", 32'(ss), 32'd0);
        if (nbytes < 2) cap[nbytes] = m_tx_data;
        nbytes++;
      end
      if (!ss_prev && ss) begin
        check("bytes_per_frame", 32'(nbytes), 32'd2);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got 0x%02h%02h, expected no frame", cap[0], cap[1]);
        end else begin
          exp_w = exp_q.pop_front();
          check("frame", {16'h0, cap[0], cap[1]}, {16'h0, exp_w});
        end
        have_prev = 1'b1;
        hi_len    = 0;
      end
      if (ss) hi_len++;
      ss_prev = ss;
    end
  end

  task automatic wait_model(input int unsigned target, input int budget, input string name);
    int n = 0;
    while (model_cnt != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (model_cnt != target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, counter at %0d, required %0d", name, model_cnt, target);
    end
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int n = 0;
    while (starts_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(starts_seen), 32'(target));
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && ss && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base;
    int n;
    reset = 1'b0;
    run   = 1'b0;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss", 32'(ss), 32'd1);
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_tx", 32'(m_tx_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Value 0 is sent once after reset release
    exp_q.push_back(16'h0000);
    reset = 1'b1;
    wait_drain(200, "t1_drain");
    check("t1_count", 32'(count), 32'd0);

    // Stall the master, tick up to 0x1234: stuck frame carries 1, follow-up carries latest
    master_en = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h1234);
    run = 1'b1;
    wait_model(32'h1234, 12000, "t2_ticks");
    run = 1'b0;
    @(negedge clk);
    check("t2_count", 32'(count), 32'h1234);
    master_en = 1'b1;
    wait_drain(400, "t2_drain");
    check("t2_b2b_gap", last_gap, EXP_GAP + 1);

    // Wrap from CNT_MAX to 0
    master_en = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(16'h1235);
    exp_q.push_back(16'h0000);
    run = 1'b1;
    wait_model(CNT_MAX, 12000, "t3_to_max");
    check("t3_count_max", 32'(count), 32'(CNT_MAX));
    wait_model(0, 10, "t3_wrap");
    run = 1'b0;
    @(negedge clk);
    check("t3_wrap_count", 32'(count), 32'd0);
    master_en = 1'b1;
    wait_drain(400, "t3_drain");

    // Three ticks while HI_WAIT is held collapse into one follow-up frame
    base     = starts_seen;
    hold_idx = base + 1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0003);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_starts(base + 1, 50, "t4_hi_start");
    run = 1'b1;
    wait_model(3, 20, "t4_ticks");
    run = 1'b0;
    @(negedge clk);
    check("t4_busy_held", 32'(busy), 32'd1);
    hold_idx = -1;
    wait_drain(400, "t4_drain");

    // Clear coincident with a tick at count 50
    master_en = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(16'h0004);
    exp_q.push_back(16'h0000);
    run = 1'b1;
    n   = 0;
    while (!(model_cnt == 50 && model_div == DIV - 1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_50", 32'(model_cnt), 32'd50);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    run   = 1'b0;
    check("t5_clear_wins", 32'(count), 32'd0);
    master_en = 1'b1;
    wait_drain(400, "t5_drain");

    // Reset during LO_WAIT abandons the frame; value 0 follows after release
    master_en = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b1;
    wait_model(5, 40, "t6_ticks");
    run = 1'b0;
    base      = starts_seen;
    hold_idx  = base + 2;
    master_en = 1'b1;
    wait_starts(base + 2, 100, "t6_lo_start");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_ss", 32'(ss), 32'd1);
    check("t6_rst_m_start", 32'(m_start), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    hold_idx = -1;
    exp_q.push_back(16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_drain(200, "t6_drain");
    check("t6_count", 32'(count), 32'd0);

    repeat (40) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
